// File: rtl/conv_apb_pkg.sv
// Shared types and default constants for the host-to-APB initiator.
// Holds the state encoding, counter type and the poll match helper.
package conv_apb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ACCESS,
      ST_GAP,
      ST_RESP
   } state_e;

   localparam int DEF_TIMEOUT_CYCLES = 1024;
   localparam int DEF_POLL_MAX       = 4096;
   localparam int DEF_POLL_GAP       = 4;

   localparam int CNT_W = 32;
   typedef logic [CNT_W-1:0] cnt_t;

   function automatic logic pollMatch(input logic [31:0] data,
                                      input logic [31:0] mask,
                                      input logic [31:0] value);
      return (data & mask) == value;
   endfunction

endpackage

// File: rtl/conv_apb_timer.sv
// Wait-state, poll-gap and poll-attempt counters for conv_apb_master.
// Each counter has its own load (to zero) and count-enable control.
module conv_apb_timer
   import conv_apb_pkg::*;
(
   input  logic CLK,
   input  logic RESETN,
   input  logic waitLoad_i,
   input  logic waitEn_i,
   input  logic gapLoad_i,
   input  logic gapEn_i,
   input  logic attLoad_i,
   input  logic attEn_i,
   output cnt_t waitCnt_o,
   output cnt_t gapCnt_o,
   output cnt_t attCnt_o
);

   cnt_t waitCnt_q;
   cnt_t gapCnt_q;
   cnt_t attCnt_q;

   // Load takes priority over enable so a restart never sees a stale count.
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         waitCnt_q <= '0;
         gapCnt_q  <= '0;
         attCnt_q  <= '0;
      end else begin
         if (waitLoad_i)   waitCnt_q <= '0;
         else if (waitEn_i) waitCnt_q <= waitCnt_q + cnt_t'(1);

         if (gapLoad_i)    gapCnt_q <= '0;
         else if (gapEn_i) gapCnt_q <= gapCnt_q + cnt_t'(1);

         if (attLoad_i)    attCnt_q <= '0;
         else if (attEn_i) attCnt_q <= attCnt_q + cnt_t'(1);
      end
   end

   assign waitCnt_o = waitCnt_q;
   assign gapCnt_o  = gapCnt_q;
   assign attCnt_o  = attCnt_q;

endmodule

// File: rtl/conv_apb.sv
// Host request/response to APB initiator with wait-state timeout and
// optional read polling until (PRDATA & mask) == value.
module conv_apb_master
   import conv_apb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int POLL_MAX       = DEF_POLL_MAX,
   parameter int POLL_GAP       = DEF_POLL_GAP
) (
   input  logic        CLK,
   input  logic        RESETN,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic        req_poll,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [31:0] req_mask,
   input  logic [31:0] req_value,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        rsp_timeout,
   output logic [31:0] PADDR,
   output logic [31:0] PWDATA,
   output logic        PSEL,
   output logic        PENABLE,
   output logic        PWRITE,
   input  logic [31:0] PRDATA,
   input  logic        PREADY,
   input  logic        PSLVERR
);

   state_e      state_q;
   logic        reqReady_q;
   logic        psel_q;
   logic        penable_q;
   logic        pwrite_q;
   logic [31:0] paddr_q;
   logic [31:0] pwdata_q;
   logic        poll_q;
   logic [31:0] mask_q;
   logic [31:0] value_q;
   logic        rspValid_q;
   logic [31:0] rspRdata_q;
   logic        rspErr_q;
   logic        rspTimeout_q;

   cnt_t waitCnt;
   cnt_t gapCnt;
   cnt_t attCnt;

   conv_apb_timer u_timer (
      .CLK        (CLK),
      .RESETN     (RESETN),
      .waitLoad_i (state_q == ST_SETUP),
      .waitEn_i   (state_q == ST_ACCESS && !PREADY),
      .gapLoad_i  (state_q == ST_ACCESS),
      .gapEn_i    (state_q == ST_GAP),
      .attLoad_i  (state_q == ST_IDLE),
      .attEn_i    (state_q == ST_ACCESS && PREADY),
      .waitCnt_o  (waitCnt),
      .gapCnt_o   (gapCnt),
      .attCnt_o   (attCnt)
   );

   // All bus and response outputs are registered alongside the state so
   // they change only on a clock edge (or drop at once on reset).
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state_q      <= ST_IDLE;
         reqReady_q   <= 1'b0;
         psel_q       <= 1'b0;
         penable_q    <= 1'b0;
         pwrite_q     <= 1'b0;
         paddr_q      <= '0;
         pwdata_q     <= '0;
         poll_q       <= 1'b0;
         mask_q       <= '0;
         value_q      <= '0;
         rspValid_q   <= 1'b0;
         rspRdata_q   <= '0;
         rspErr_q     <= 1'b0;
         rspTimeout_q <= 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               reqReady_q <= 1'b1;
               if (req_valid && reqReady_q) begin
                  reqReady_q <= 1'b0;
                  paddr_q    <= req_addr;
                  pwdata_q   <= req_wdata;
                  pwrite_q   <= req_write;
                  poll_q     <= req_poll & ~req_write;
                  mask_q     <= req_mask;
                  value_q    <= req_value;
                  psel_q     <= 1'b1;
                  state_q    <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               penable_q <= 1'b1;
               state_q   <= ST_ACCESS;
            end
            ST_ACCESS: begin
               if (PREADY) begin
                  psel_q    <= 1'b0;
                  penable_q <= 1'b0;
                  if (!poll_q || PSLVERR || pollMatch(PRDATA, mask_q, value_q)) begin
                     rspValid_q   <= 1'b1;
                     rspRdata_q   <= pwrite_q ? 32'h0 : PRDATA;
                     rspErr_q     <= PSLVERR;
                     rspTimeout_q <= 1'b0;
                     state_q      <= ST_RESP;
                  end else if (attCnt == cnt_t'(POLL_MAX - 1)) begin
                     rspValid_q   <= 1'b1;
                     rspRdata_q   <= PRDATA;
                     rspErr_q     <= 1'b1;
                     rspTimeout_q <= 1'b1;
                     state_q      <= ST_RESP;
                  end else if (POLL_GAP == 0) begin
                     psel_q  <= 1'b1;
                     state_q <= ST_SETUP;
                  end else begin
                     state_q <= ST_GAP;
                  end
               end else if (waitCnt == cnt_t'(TIMEOUT_CYCLES - 1)) begin
                  // This is the last allowed wait cycle: abandon the transfer.
                  psel_q       <= 1'b0;
                  penable_q    <= 1'b0;
                  rspValid_q   <= 1'b1;
                  rspRdata_q   <= '0;
                  rspErr_q     <= 1'b1;
                  rspTimeout_q <= 1'b1;
                  state_q      <= ST_RESP;
               end
            end
            ST_GAP: begin
               if (gapCnt == cnt_t'(POLL_GAP - 1)) begin
                  psel_q  <= 1'b1;
                  state_q <= ST_SETUP;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rspValid_q   <= 1'b0;
                  rspRdata_q   <= '0;
                  rspErr_q     <= 1'b0;
                  rspTimeout_q <= 1'b0;
                  reqReady_q   <= 1'b1;
                  state_q      <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign req_ready   = reqReady_q;
   assign rsp_valid   = rspValid_q;
   assign rsp_rdata   = rspRdata_q;
   assign rsp_err     = rspErr_q;
   assign rsp_timeout = rspTimeout_q;
   assign PADDR       = paddr_q;
   assign PWDATA      = pwdata_q;
   assign PSEL        = psel_q;
   assign PENABLE     = penable_q;
   assign PWRITE      = pwrite_q;

endmodule

// File: tb/tb_conv_apb_master.sv
// Randomized bench for conv_apb_master: a scripted APB responder plus a
// per-request reference model of response, latency, attempts and gaps.
module tb_conv_apb_master;

   localparam int TO  = 8;
   localparam int PM  = 5;
   localparam int GAP = 4;

   logic        CLK;
   logic        RESETN;
   logic        req_valid, req_ready, req_write, req_poll;
   logic [31:0] req_addr, req_wdata, req_mask, req_value;
   logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
   logic [31:0] rsp_rdata;
   logic [31:0] PADDR, PWDATA, PRDATA;
   logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;

   int compared   = 0;
   int mismatched = 0;

   // Responder script, one entry per APB attempt of the current request.
   int          planWait [8];
   logic [31:0] planData [8];
   bit          planErr  [8];
   int          att, waitCtr;
   bit          apbDone;

   // Monitor bookkeeping for the current request.
   logic [31:0] curAddr, curWdata;
   bit          curWrite;
   bit          busy;
   int          setupCnt, gapRun;
   int          gapQ[$];

   conv_apb_master #(
      .TIMEOUT_CYCLES (TO),
      .POLL_MAX       (PM),
      .POLL_GAP       (GAP)
   ) dut (
      .CLK         (CLK),
      .RESETN      (RESETN),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_write   (req_write),
      .req_poll    (req_poll),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .req_mask    (req_mask),
      .req_value   (req_value),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_rdata   (rsp_rdata),
      .rsp_err     (rsp_err),
      .rsp_timeout (rsp_timeout),
      .PADDR       (PADDR),
      .PWDATA      (PWDATA),
      .PSEL        (PSEL),
      .PENABLE     (PENABLE),
      .PWRITE      (PWRITE),
      .PRDATA      (PRDATA),
      .PREADY      (PREADY),
      .PSLVERR     (PSLVERR)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish (got running, expected done)");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // Responder: PREADY goes high once the scripted number of wait cycles has
   // elapsed; PRDATA carries garbage whenever PREADY is low.
   initial begin
      PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
      att = 0; waitCtr = 0; apbDone = 0;
      forever begin
         @(negedge CLK);
         if (apbDone) begin
            att++;
            waitCtr = 0;
            apbDone = 0;
         end
         PREADY  = 1'b0;
         PSLVERR = 1'b0;
         PRDATA  = $urandom;
         if (RESETN && PSEL && PENABLE) begin
            if (waitCtr >= planWait[att < 8 ? att : 7]) begin
               PREADY  = 1'b1;
               PRDATA  = planData[att < 8 ? att : 7];
               PSLVERR = planErr[att < 8 ? att : 7];
               apbDone = 1;
            end else begin
               waitCtr++;
            end
         end
      end
   end

   // Bus protocol monitor, sampled mid-cycle.
   initial begin
      setupCnt = 0; gapRun = 0; busy = 0;
      forever begin
         @(negedge CLK);
         checkOutput("penNoSel", PENABLE & ~PSEL, 0);
         checkOutput("pselIdleResp", PSEL & (rsp_valid | req_ready), 0);
         if (PSEL) begin
            checkOutput("paddr", PADDR, curAddr);
            checkOutput("pwrite", PWRITE, curWrite);
            checkOutput("pwdata", PWDATA, curWdata);
         end
         if (PSEL && !PENABLE) begin
            setupCnt++;
            if (gapRun > 0) gapQ.push_back(gapRun);
            gapRun = 0;
         end else if (busy && !PSEL && !rsp_valid) begin
            gapRun++;
         end
      end
   end

   // Reference model: walk the responder script attempt by attempt.
   function automatic void modelRequest(input bit wr, input bit pl,
                                        input logic [31:0] mask, input logic [31:0] value,
                                        output bit eErr, output bit eTo,
                                        output logic [31:0] eData,
                                        output int eAtt, output int eLat);
      eErr = 0; eTo = 0; eData = '0; eAtt = 0; eLat = 0;
      for (int k = 0; k < 8; k++) begin
         eLat += 1;
         eAtt++;
         if (planWait[k] >= TO) begin
            eLat += TO; eErr = 1; eTo = 1; eData = '0;
            break;
         end
         eLat += planWait[k] + 1;
         if (wr) begin
            eErr = planErr[k]; eData = '0;
            break;
         end
         if (!pl || planErr[k] || ((planData[k] & mask) == value)) begin
            eErr = planErr[k]; eData = planData[k];
            break;
         end
         if (k + 1 == PM) begin
            eErr = 1; eTo = 1; eData = planData[k];
            break;
         end
         eLat += GAP;
      end
      eLat += 1;
   endfunction

   task automatic applyStimulus(input bit wr, input bit pl,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] mask, input logic [31:0] value);
      bit          eErr, eTo;
      logic [31:0] eData;
      int          eAtt, eLat, lat, n, hold;
      modelRequest(wr, pl, mask, value, eErr, eTo, eData, eAtt, eLat);
      @(negedge CLK);
      att = 0; waitCtr = 0; apbDone = 0;
      setupCnt = 0; gapRun = 0; gapQ.delete();
      curAddr = addr; curWdata = wdata; curWrite = wr;
      req_valid = 1'b1; req_write = wr; req_poll = pl;
      req_addr = addr; req_wdata = wdata; req_mask = mask; req_value = value;
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge CLK);
         n++;
      end
      checkOutput("reqReady", req_ready, 1);
      if (!req_ready) begin
         req_valid = 1'b0;
         return;
      end
      @(negedge CLK);
      busy = 1;
      req_valid = 1'b0;
      req_write = $urandom_range(0, 1); req_poll = $urandom_range(0, 1);
      req_addr = $urandom; req_wdata = $urandom; req_mask = $urandom; req_value = $urandom;
      checkOutput("setupPhase", {PSEL, PENABLE}, 2'b10);
      checkOutput("setupReqRdy", req_ready, 0);
      @(negedge CLK);
      lat = 2;
      checkOutput("accessPhase", {PSEL, PENABLE}, 2'b11);
      while (!rsp_valid && lat < 300) begin
         @(negedge CLK);
         lat++;
      end
      busy = 0;
      checkOutput("rspValid", rsp_valid, 1);
      if (!rsp_valid) return;
      checkOutput("latency", lat, eLat);
      checkOutput("attempts", setupCnt, eAtt);
      checkOutput("gapCount", gapQ.size(), eAtt - 1);
      foreach (gapQ[i]) checkOutput("gapLen", gapQ[i], GAP);
      hold = $urandom_range(0, 3);
      for (int h = 0; h <= hold; h++) begin
         checkOutput("rspRdata", rsp_rdata, eData);
         checkOutput("rspErr", rsp_err, eErr);
         checkOutput("rspTimeout", rsp_timeout, eTo);
         checkOutput("rspHold", rsp_valid, 1);
         if (h < hold) @(negedge CLK);
      end
      rsp_ready = 1'b1;
      checkOutput("respReqRdy", req_ready, 0);
      @(negedge CLK);
      rsp_ready = 1'b0;
      checkOutput("rspDrop", rsp_valid, 0);
      checkOutput("idleReqRdy", req_ready, 1);
   endtask

   function automatic int pickWait();
      int r;
      r = $urandom_range(0, 19);
      if (r < 10)  return 0;
      if (r < 15)  return $urandom_range(1, 3);
      if (r == 15) return TO - 1;
      if (r == 16) return TO;
      if (r == 17) return TO + 5;
      return $urandom_range(4, TO - 2);
   endfunction

   task automatic clearPlan();
      for (int k = 0; k < 8; k++) begin
         planWait[k] = 0;
         planData[k] = $urandom;
         planErr[k]  = 0;
      end
   endtask

   initial begin
      bit          wr, pl;
      logic [31:0] mask, value;
      RESETN = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_poll = 1'b0;
      req_addr = '0; req_wdata = '0; req_mask = '0; req_value = '0; rsp_ready = 1'b0;
      curAddr = '0; curWdata = '0; curWrite = 0;
      clearPlan();

      repeat (3) @(negedge CLK);
      checkOutput("rstPsel", {PSEL, PENABLE, PWRITE}, 0);
      checkOutput("rstPaddr", PADDR, 0);
      checkOutput("rstPwdata", PWDATA, 0);
      checkOutput("rstHost", {req_ready, rsp_valid, rsp_err, rsp_timeout}, 0);
      checkOutput("rstRdata", rsp_rdata, 0);
      RESETN = 1'b1;
      @(negedge CLK);
      checkOutput("rdyAfterReset", req_ready, 1);

      $display("[TB] write, zero wait states");
      clearPlan();
      applyStimulus(1, 0, 32'h0000_0004, 32'h0000_0010, 0, 0);

      $display("[TB] read, 3 wait states");
      clearPlan(); planWait[0] = 3; planData[0] = 32'hDEAD_BEEF;
      applyStimulus(0, 0, 32'h0000_0100, 32'h0, 0, 0);

      $display("[TB] poll, match on third read");
      clearPlan(); planData[0] = 0; planData[1] = 0; planData[2] = 1;
      applyStimulus(0, 1, 32'h0000_0200, 32'h0, 32'h1, 32'h1);

      $display("[TB] PREADY stuck low");
      clearPlan(); planWait[0] = 100;
      applyStimulus(0, 0, 32'h0000_0300, 32'h0, 0, 0);

      $display("[TB] wait states one below timeout");
      clearPlan(); planWait[0] = TO - 1; planData[0] = 32'h1234_5678;
      applyStimulus(0, 0, 32'h0000_0304, 32'h0, 0, 0);

      $display("[TB] PSLVERR on plain read and on poll");
      clearPlan(); planErr[0] = 1; planData[0] = 32'h0000_0055;
      applyStimulus(0, 0, 32'h0000_0400, 32'h0, 0, 0);
      clearPlan(); planErr[0] = 1; planData[0] = 32'h0000_0066;
      applyStimulus(0, 1, 32'h0000_0404, 32'h0, 32'h1, 32'h1);

      $display("[TB] poll limit reached");
      clearPlan();
      for (int k = 0; k < 8; k++) planData[k] = 32'h100 + k;
      applyStimulus(0, 1, 32'h0000_0500, 32'h0, 32'h1, 32'h1);

      $display("[TB] reset during ACCESS");
      clearPlan(); planWait[0] = 50;
      @(negedge CLK);
      att = 0; waitCtr = 0; apbDone = 0;
      curAddr = 32'hA5A5_0000; curWdata = 32'h5A5A_5A5A; curWrite = 1;
      req_valid = 1'b1; req_write = 1'b1; req_poll = 1'b0;
      req_addr = curAddr; req_wdata = curWdata;
      for (int n = 0; n < 20 && !req_ready; n++) @(negedge CLK);
      @(negedge CLK);
      req_valid = 1'b0;
      @(negedge CLK);
      checkOutput("preReset", {PSEL, PENABLE}, 2'b11);
      #2 RESETN = 1'b0;
      #1;
      checkOutput("resetDropsBus", {PSEL, PENABLE}, 0);
      checkOutput("resetNoRsp", rsp_valid, 0);
      @(negedge CLK);
      RESETN = 1'b1;
      @(negedge CLK);
      checkOutput("rdyAfterMidReset", req_ready, 1);
      for (int n = 0; n < 3; n++) begin
         @(negedge CLK);
         checkOutput("noRspAfterReset", rsp_valid, 0);
      end

      $display("[TB] randomized requests");
      for (int t = 0; t < 60; t++) begin
         wr    = ($urandom_range(0, 3) == 0);
         pl    = $urandom_range(0, 1);
         mask  = $urandom & $urandom & $urandom;
         value = $urandom & mask;
         for (int k = 0; k < 8; k++) begin
            planWait[k] = pickWait();
            planErr[k]  = ($urandom_range(0, 9) == 0);
            planData[k] = ($urandom_range(0, 2) == 0) ? (($urandom & ~mask) | value) : $urandom;
         end
         applyStimulus(wr, pl, $urandom, $urandom, mask, value);
      end

      repeat (2) @(negedge CLK);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/conv_apb_master.md
CONV_APB_MASTER -- requirements
Module: conv_apb_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024: maximum consecutive ACCESS cycles with PREADY=0 before the transfer is aborted.
REQ-002 Parameter POLL_MAX, default 4096: maximum read attempts for one poll request.
REQ-003 Parameter POLL_GAP, default 4: idle cycles between poll attempts.
REQ-004 CLK  in  1  single clock; all logic is rising-edge.
REQ-005 RESETN  in  1  asynchronous, active-low reset.
REQ-006 req_valid  in  1  host request present.
REQ-007 req_ready  out  1  request accepted when req_valid and req_ready are both 1.
REQ-008 req_write  in  1  1 = APB write, 0 = APB read.
REQ-009 req_poll  in  1  repeat the read until the match condition holds; ignored when req_write=1.
REQ-010 req_addr  in  32  APB address.
REQ-011 req_wdata  in  32  write data.
REQ-012 req_mask, req_value  in  32 each  poll match terms: (PRDATA & req_mask) == req_value.
REQ-013 rsp_valid  out  1  response present; held until rsp_ready.
REQ-014 rsp_ready  in  1  host consumes the response.
REQ-015 rsp_rdata  out  32  last captured PRDATA; 0 for writes.
REQ-016 rsp_err  out  1  PSLVERR seen, or a timeout occurred.
REQ-017 rsp_timeout  out  1  a PREADY timeout or a poll-limit timeout occurred.
REQ-018 PADDR, PWDATA  out  32 each; PSEL, PENABLE, PWRITE  out  1 each  APB initiator outputs.
REQ-019 PRDATA  in  32; PREADY, PSLVERR  in  1 each  APB responder returns.

Function
REQ-020 The state machine SHALL have these states: IDLE, SETUP, ACCESS, GAP, RESP.
REQ-021 req_ready SHALL be 1 only in IDLE.
- On acceptance, addr, wdata, write, poll, mask and value are latched.
- The machine then goes to SETUP.
REQ-022 SETUP: PSEL=1, PENABLE=0, and PADDR/PWRITE/PWDATA are driven from the latched values. SETUP SHALL last exactly one cycle and always go to ACCESS.
REQ-023 ACCESS: PSEL=1, PENABLE=1, with PADDR/PWRITE/PWDATA unchanged. On PREADY=1, PRDATA and PSLVERR are captured and PSEL/PENABLE drop on the next cycle.
REQ-024 Minimum latency with PREADY=1 from the first ACCESS cycle:
- accept at cycle N, SETUP at N+1, ACCESS at N+2;
- rsp_valid=1 at N+3.
REQ-025 Wait-state counter:
- increments on each ACCESS cycle with PREADY=0;
- clears on every SETUP.
REQ-026 When the wait-state counter reaches TIMEOUT_CYCLES, the machine SHALL:
- deassert PSEL/PENABLE;
- go to RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-027 Poll mode, after each completed read:
- match or PSLVERR=1: go to RESP;
- otherwise: go to GAP for POLL_GAP cycles with PSEL=0, then SETUP again.
REQ-028 The poll attempt counter SHALL increment per completed read. If POLL_MAX attempts complete without a match:
- go to RESP with rsp_timeout=1 and rsp_err=1;
- rsp_rdata = the last PRDATA read.
REQ-029 RESP: rsp_valid=1 with all rsp_* outputs stable until the cycle where rsp_ready=1, then IDLE. A new request cannot be accepted in that same cycle.
REQ-030 For a write, rsp_rdata SHALL be 0.
REQ-031 PSEL SHALL never be 1 in IDLE, GAP or RESP. PENABLE SHALL never be 1 without PSEL.

Reset
REQ-032 While RESETN=0, these outputs SHALL be 0 and the state SHALL be IDLE:
- PSEL, PENABLE, PWRITE, PADDR, PWDATA;
- req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout.
REQ-033 Asserting RESETN mid-transfer SHALL:
- drop PSEL/PENABLE asynchronously;
- discard the pending request with no response issued.
REQ-034 req_ready SHALL rise in the first clock cycle after RESETN deasserts.

Structure
REQ-035 The state encoding and the default TIMEOUT_CYCLES/POLL_MAX/POLL_GAP constants SHALL live in the shared package conv_apb_pkg.
REQ-036 The wait-state, gap and attempt counting SHALL be one sub-module, conv_apb_timer, instanced with separate load/enable controls per counter.

Verification
REQ-037 Write, zero wait states: addr 0x0000_0004, wdata 0x0000_0010.
- PSEL at N+1; PENABLE at N+2; rsp_valid at N+3.
- rsp_err=0, rsp_rdata=0.
REQ-038 Read with 3 wait states, PRDATA=0xDEAD_BEEF: ACCESS lasts 4 cycles; rsp_rdata=0xDEAD_BEEF; PADDR stable throughout.
REQ-039 Poll: mask=0x1, value=0x1; the responder returns 0 twice, then 1.
- 3 APB reads occur, each separated by 4 PSEL=0 cycles.
- rsp_rdata=0x1, rsp_err=0.
REQ-040 PREADY held at 0 with TIMEOUT_CYCLES=8: after 8 ACCESS cycles, PSEL drops and rsp_err=1, rsp_timeout=1.
REQ-041 PSLVERR=1 on a read: rsp_err=1, rsp_timeout=0; with req_poll=1, no retry occurs.
REQ-042 RESETN pulsed low during ACCESS: PSEL=0 immediately, no rsp_valid, req_ready=1 in the first cycle after release.
